table_stream_reader: RTL and testbench

TABLE_STREAM_READER -- requirements
Module: table_stream_reader

---
 rtl/table_stream_reader.sv | 200 ++++++++++++++++++++
 tb/tb_table_stream_reader.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/table_stream_reader.sv
// table_stream_reader: walks a contiguous, wrap-around range of a registered
// lookup table OUTPUT_RATE entries at a time and streams the entries out as
// keep-masked beats over a valid/ready handshake.

// One read lane: its table index is the scan cursor plus a fixed offset, and
// its captured data is masked when the lane lies past the remaining count.
module table_stream_reader_lane #(
  parameter int TABLE_SIZE = 32,
  parameter int DATA_WIDTH = 8,
  parameter int LANE       = 0,
  localparam int IDX       = $clog2(TABLE_SIZE),
  localparam int RW        = IDX + 1
) (
  input  logic [IDX-1:0]        cur,
  input  logic [RW-1:0]         rem,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [IDX-1:0]        idx,
  output logic                  keep,
  output logic [DATA_WIDTH-1:0] data
);

  logic [RW-1:0] sum;

  // Lane index modulo TABLE_SIZE; a single subtract is enough since LANE < TABLE_SIZE.
  always_comb begin
    sum = {1'b0, cur} + RW'(LANE);
    if (sum >= RW'(TABLE_SIZE)) sum = sum - RW'(TABLE_SIZE);
    idx = sum[IDX-1:0];
  end

  // Kept in separate assigns so the masking path does not depend on the cursor.
  assign keep = (rem > RW'(LANE));
  assign data = keep ? rd_data : '0;

endmodule

module table_stream_reader #(
  parameter int TABLE_SIZE  = 32,
  parameter int DATA_WIDTH  = 8,
  parameter int OUTPUT_RATE = 2,
  localparam int IDX        = $clog2(TABLE_SIZE),
  localparam int RW         = IDX + 1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
  input  logic [IDX-1:0]                  base_idx,
  input  logic [RW-1:0]                   length,
  output logic                            busy,
  output logic                            done,
  output logic                            tbl_rd_en,
  output logic [OUTPUT_RATE*IDX-1:0]      tbl_index_rd,
  input  logic [OUTPUT_RATE*DATA_WIDTH-1:0] tbl_data_rd,
  output logic                            m_valid,
  input  logic                            m_ready,
  output logic [OUTPUT_RATE*DATA_WIDTH-1:0] m_data,
  output logic [OUTPUT_RATE-1:0]          m_keep,
  output logic                            m_last
);

  typedef enum logic [1:0] {IDLE, REQ, CAPT, OUT} state_t;

  state_t state_q, state_d;
  logic [IDX-1:0] cur_q, cur_d;
  logic [RW-1:0]  rem_q, rem_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic           rd_en_q, rd_en_d;
  logic           valid_q, valid_d;
  logic           last_q, last_d;
  logic [OUTPUT_RATE-1:0]                 keep_q, keep_d;
  logic [OUTPUT_RATE-1:0][DATA_WIDTH-1:0] data_q, data_d;
  logic [OUTPUT_RATE-1:0][IDX-1:0]        index_q, index_d;

  logic [OUTPUT_RATE-1:0][DATA_WIDTH-1:0] rd_lanes;
  logic [OUTPUT_RATE-1:0][DATA_WIDTH-1:0] lane_data;
  logic [OUTPUT_RATE-1:0][IDX-1:0]        lane_idx;
  logic [OUTPUT_RATE-1:0]                 lane_keep;
  logic [RW-1:0]                          len_clamp;
  logic [RW:0]                            cur_sum;
  logic [IDX-1:0]                         cur_adv;

  assign rd_lanes  = tbl_data_rd;
  assign len_clamp = (length > RW'(TABLE_SIZE)) ? RW'(TABLE_SIZE) : length;

  // Lanes index from the next cursor so the read address is ready on entry to REQ.
  for (genvar k = 0; k < OUTPUT_RATE; k++) begin : g_lane
    table_stream_reader_lane #(
      .TABLE_SIZE(TABLE_SIZE),
      .DATA_WIDTH(DATA_WIDTH),
      .LANE      (k)
    ) u_lane (
      .cur    (cur_d),
      .rem    (rem_q),
      .rd_data(rd_lanes[k]),
      .idx    (lane_idx[k]),
      .keep   (lane_keep[k]),
      .data   (lane_data[k])
    );
  end

  // Cursor advance by one beat, wrapping at TABLE_SIZE.
  always_comb begin
    cur_sum = {2'b00, cur_q} + (RW + 1)'(OUTPUT_RATE);
    if (cur_sum >= (RW + 1)'(TABLE_SIZE)) cur_sum = cur_sum - (RW + 1)'(TABLE_SIZE);
    cur_adv = cur_sum[IDX-1:0];
  end

  // Next-state and next-output logic for the IDLE/REQ/CAPT/OUT scan sequence.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    data_d  = data_q;
    keep_d  = keep_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (len_clamp != '0) begin
            cur_d   = base_idx;
            rem_d   = len_clamp;
            state_d = REQ;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      REQ:  state_d = CAPT;
      CAPT: begin
        data_d  = lane_data;
        keep_d  = lane_keep;
        last_d  = (rem_q <= RW'(OUTPUT_RATE));
        state_d = OUT;
      end
      OUT: begin
        if (m_ready) begin
          if (rem_q > RW'(OUTPUT_RATE)) begin
            cur_d   = cur_adv;
            rem_d   = rem_q - RW'(OUTPUT_RATE);
            state_d = REQ;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d  = (state_d != IDLE);
    rd_en_d = (state_d == REQ);
    valid_d = (state_d == OUT);
  end

  // Read indices are launched together with the read enable and held otherwise.
  always_comb begin
    index_d = index_q;
    if (state_d == REQ) index_d = lane_idx;
  end

  // State and registered outputs; reset drops any scan in flight without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cur_q   <= '0;
      rem_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_en_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      keep_q  <= '0;
      data_q  <= '0;
      index_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      rem_q   <= rem_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_en_q <= rd_en_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      keep_q  <= keep_d;
      data_q  <= data_d;
      index_q <= index_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign tbl_rd_en    = rd_en_q;
  assign tbl_index_rd = index_q;
  assign m_valid      = valid_q;
  assign m_data       = data_q;
  assign m_keep       = keep_q;
  assign m_last       = last_q;

endmodule

// File: tb/tb_table_stream_reader.sv
// Bench for table_stream_reader: a table model answers reads one cycle later,
// a scan-level reference model queues expected indices and beats, and a
// negedge monitor pops and compares whatever the DUT presents.
module tb_table_stream_reader;
  localparam int TS = 32, DW = 8, OR = 2, IDX = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic [IDX-1:0] base_idx = '0;
  logic [IDX:0] length = '0;
  logic busy, done, tbl_rd_en, m_valid, m_last;
  logic m_ready = 1'b0;
  logic [OR*IDX-1:0] tbl_index_rd;
  logic [OR*DW-1:0] tbl_data_rd = '0;
  logic [OR*DW-1:0] m_data;
  logic [OR-1:0] m_keep;

  int checks = 0, errors = 0;
  logic [DW-1:0] mem [TS];

  typedef struct packed {
    logic [OR*DW-1:0] data;
    logic [OR-1:0]    keep;
    logic             last;
  } beat_t;
  beat_t beat_q[$];
  logic [OR*IDX-1:0] idx_q[$];

  int rdy_mode = 1;   // 0 random, 1 high, 2 low
  int run_mode = 1;

  always #5 clk = ~clk;

  table_stream_reader #(.TABLE_SIZE(TS), .DATA_WIDTH(DW), .OUTPUT_RATE(OR)) dut (
    .clk(clk), .rst(rst), .start(start), .base_idx(base_idx), .length(length),
    .busy(busy), .done(done), .tbl_rd_en(tbl_rd_en), .tbl_index_rd(tbl_index_rd),
    .tbl_data_rd(tbl_data_rd), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_keep(m_keep), .m_last(m_last)
  );

  // registered table: data appears the cycle after the read enable
  always @(posedge clk)
    if (tbl_rd_en)
      for (int k = 0; k < OR; k++) tbl_data_rd[k*DW +: DW] <= mem[tbl_index_rd[k*IDX +: IDX]];

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       m_ready = 1'($urandom_range(0, 1));
      1:       m_ready = 1'b1;
      default: m_ready = 1'b0;
    endcase
  end

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // reference: entries base..base+n-1 (mod TS) split into OR-wide beats
  task automatic push_model(int base, int len);
    int n, nb, j, a;
    beat_t bt;
    logic [OR*IDX-1:0] iv;
    n  = (len > TS) ? TS : len;
    nb = (n + OR - 1) / OR;
    for (int b = 0; b < nb; b++) begin
      bt = '0;
      iv = '0;
      for (int k = 0; k < OR; k++) begin
        j = b * OR + k;
        a = (base + j) % TS;
        iv[k*IDX +: IDX] = a[IDX-1:0];
        if (j < n) begin
          bt.data[k*DW +: DW] = mem[a];
          bt.keep[k] = 1'b1;
        end
      end
      bt.last = (b == nb - 1);
      beat_q.push_back(bt);
      idx_q.push_back(iv);
    end
  endtask

  // monitor
  int cyc = 0, evt = -100;
  bit pv = 0, stalled = 0;
  logic [OR*DW-1:0] pd;
  logic [OR-1:0] pk;
  logic pl;
  beat_t eb;
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      pv = 0;
      stalled = 0;
    end else begin
      if (done) chk("busy_at_done", busy, 0);
      if (tbl_rd_en) begin
        chk("read_expected", idx_q.size() != 0, 1);
        if (idx_q.size() != 0) chk("rd_index", tbl_index_rd, idx_q.pop_front());
      end
      if (m_valid) begin
        chk("rd_en_in_out", tbl_rd_en, 0);
        if (!pv) chk("latency", cyc - evt, 3);
        if (stalled) chk("stall_stable", {m_data, m_keep, m_last}, {pd, pk, pl});
        if (m_ready) begin
          chk("beat_expected", beat_q.size() != 0, 1);
          if (beat_q.size() != 0) begin
            eb = beat_q.pop_front();
            chk("beat", {m_data, m_keep, m_last}, eb);
          end
          evt = cyc;
        end
      end
      if (start && !busy && length != 0) evt = cyc;
      stalled = m_valid && !m_ready;
      pd = m_data; pk = m_keep; pl = m_last; pv = m_valid;
    end
  end

  task automatic scan(int base, int len, int stall);
    int n, t;
    n = (len > TS) ? TS : len;
    t = 0;
    while (busy && t < 200) begin @(posedge clk); #1; t++; end
    push_model(base, len);
    rdy_mode = (stall > 0) ? 2 : run_mode;
    start = 1'b1; base_idx = IDX'(base); length = (IDX+1)'(len);
    @(posedge clk); #1;
    start = 1'b0;
    if (n == 0) begin
      chk("zero_len_done", done, 1);
      repeat (4) begin
        @(posedge clk); #1;
        chk("zero_len_quiet", {tbl_rd_en, m_valid, busy, done}, 0);
      end
    end else begin
      if (stall > 0) begin
        t = 0;
        while (!m_valid && t < 20) begin @(posedge clk); #1; t++; end
        chk("stall_reach_out", m_valid, 1);
        start = 1'b1; base_idx = '0; length = 6'd2;  // must be ignored while busy
        repeat (stall) begin @(posedge clk); #1; start = 1'b0; end
        chk("stall_held", {m_valid, tbl_rd_en}, 2'b10);
        rdy_mode = run_mode;
      end
      t = 0;
      while (!done && t < 500) begin @(posedge clk); #1; t++; end
      chk("done_seen", done, 1);
      @(posedge clk); #1;
      chk("done_single", done, 0);
    end
    chk("queues_drained", beat_q.size() + idx_q.size(), 0);
  endtask

  initial begin
    int t;
    #500_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    int t;
    for (int i = 0; i < TS; i++) mem[i] = DW'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, tbl_rd_en, m_valid, m_last, m_keep, m_data, tbl_index_rd}, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    scan(4, 4, 0);     // {5,4},{7,6}
    scan(30, 4, 0);    // wrap: {31,30},{1,0}
    scan(0, 3, 0);     // partial last beat
    scan(0, 0, 0);     // empty scan
    scan(10, 6, 10);   // back-pressure on first beat

    // reset while holding a beat in OUT
    push_model(0, 8);
    rdy_mode = 2;
    start = 1'b1; base_idx = '0; length = 6'd8;
    @(posedge clk); #1;
    start = 1'b0;
    t = 0;
    while (!m_valid && t < 20) begin @(posedge clk); #1; t++; end
    chk("abort_reach_out", m_valid, 1);
    repeat (2) @(posedge clk);
    #1; rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_outputs_zero", {busy, done, tbl_rd_en, m_valid, m_last, m_keep, m_data, tbl_index_rd}, 0);
    beat_q.delete();
    idx_q.delete();
    rst = 1'b1;
    rdy_mode = 1;
    repeat (6) begin @(posedge clk); #1; chk("no_done_after_abort", done, 0); end
    scan(3, 5, 0);

    // randomized table contents, ranges and back-pressure
    for (int i = 0; i < TS; i++) mem[i] = DW'($urandom);
    run_mode = 0;
    for (int s = 0; s < 25; s++)
      scan(int'($urandom_range(0, TS - 1)), int'($urandom_range(0, 45)),
           ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : 0);
    run_mode = 1;
    rdy_mode = 1;
    repeat (3) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
